otbn_pq_trcu_seq: RTL

- Twiddle recompute unit directly downstream of the PQ decoder and upstream of the PQ ALU.
- Holds the twiddle, omega[0..7], psi[0..7], omega_idx and psi_idx registers, and executes twiddle/omega/psi update ops.
- Uses a 3-stage pipelined Montgomery multiplier with R=2^32.
- Drives the twiddle operand consumed by the butterfly ALU, and busy back-pressure to the controller.

---
 rtl/otbn_pq_pkg.sv | 52 +++++
 rtl/otbn_pq_mont_mul.sv | 64 ++++++
 rtl/otbn_pq_trcu_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/otbn_pq_pkg.sv
// otbn_pq_pkg: shared types and constants for the PQ datapath.
// Holds the twiddle recompute unit's op and ISPR-select encodings, the
// sequencer state type and the Montgomery multiplier latency.
package otbn_pq_pkg;

   localparam int PQLEN          = 32;  // datapath word width
   localparam int NSlots         = 8;   // omega/psi slots per WLEN
   localparam int TrcuMulLatency = 3;   // Montgomery pipeline depth

   typedef enum logic [2:0] {
      TRCU_OP_NONE        = 3'd0,
      TRCU_OP_UPD_TWIDDLE = 3'd1,
      TRCU_OP_UPD_OMEGA   = 3'd2,
      TRCU_OP_UPD_PSI     = 3'd3,
      TRCU_OP_SET_TW_PSI  = 3'd4,
      TRCU_OP_INV_TWIDDLE = 3'd5
   } trcu_op_e;

   typedef enum logic [4:0] {
      TRCU_WSEL_TWIDDLE   = 5'd0,
      TRCU_WSEL_OMEGA0    = 5'd1,
      TRCU_WSEL_OMEGA1    = 5'd2,
      TRCU_WSEL_OMEGA2    = 5'd3,
      TRCU_WSEL_OMEGA3    = 5'd4,
      TRCU_WSEL_OMEGA4    = 5'd5,
      TRCU_WSEL_OMEGA5    = 5'd6,
      TRCU_WSEL_OMEGA6    = 5'd7,
      TRCU_WSEL_OMEGA7    = 5'd8,
      TRCU_WSEL_PSI0      = 5'd9,
      TRCU_WSEL_PSI1      = 5'd10,
      TRCU_WSEL_PSI2      = 5'd11,
      TRCU_WSEL_PSI3      = 5'd12,
      TRCU_WSEL_PSI4      = 5'd13,
      TRCU_WSEL_PSI5      = 5'd14,
      TRCU_WSEL_PSI6      = 5'd15,
      TRCU_WSEL_PSI7      = 5'd16,
      TRCU_WSEL_OMEGA_IDX = 5'd17,
      TRCU_WSEL_PSI_IDX   = 5'd18
   } trcu_wsel_e;

   // Sequencer state: idle, or a multiply op in flight.
   typedef enum logic [0:0] {
      TRCU_IDLE = 1'b0,
      TRCU_BUSY = 1'b1
   } trcu_state_e;

   function automatic logic trcu_is_mul(input trcu_op_e op);
      return (op == TRCU_OP_UPD_TWIDDLE) || (op == TRCU_OP_UPD_OMEGA) ||
             (op == TRCU_OP_UPD_PSI);
   endfunction

endpackage

// File: rtl/otbn_pq_mont_mul.sv
// otbn_pq_mont_mul: 3-stage pipelined Montgomery multiplier, R = 2^32.
// Computes a*b*R^-1 mod q for a, b < q < 2^31.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   in_valid_i           operands a_i/b_i are valid this cycle
//   a_i, b_i             operands (< q)
//   prime_i              modulus q (held stable while an op is in flight)
//   prime_dash_i         -q^-1 mod 2^32
//   out_valid_o, res_o   result, three cycles after in_valid_i
module otbn_pq_mont_mul
   import otbn_pq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic [PQLEN-1:0] a_i,
   input  logic [PQLEN-1:0] b_i,
   input  logic [PQLEN-1:0] prime_i,
   input  logic [PQLEN-1:0] prime_dash_i,
   output logic             out_valid_o,
   output logic [PQLEN-1:0] res_o
);

   logic [2*PQLEN-1:0] r_p1;
   logic [2*PQLEN-1:0] r_p2;
   logic [PQLEN-1:0]   r_m;
   logic [PQLEN-1:0]   r_res;
   logic               r_v1, r_v2, r_v3;

   logic [PQLEN-1:0]   w_m;
   logic [2*PQLEN-1:0] w_mq;
   logic [PQLEN:0]     w_t;

   // m only needs the low word of p*q'; the product truncates naturally.
   assign w_m  = r_p1[PQLEN-1:0] * prime_dash_i;
   assign w_mq = (2*PQLEN)'(r_m) * (2*PQLEN)'(prime_i);
   // p + m*q is an exact multiple of 2^32; keep the 33-bit quotient (< 2q).
   assign w_t  = (PQLEN+1)'(((2*PQLEN+1)'(r_p2) + (2*PQLEN+1)'(w_mq)) >> PQLEN);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_p1  <= '0;
         r_p2  <= '0;
         r_m   <= '0;
         r_res <= '0;
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
      end else begin
         r_p1  <= (2*PQLEN)'(a_i) * (2*PQLEN)'(b_i);
         r_v1  <= in_valid_i;
         r_p2  <= r_p1;
         r_m   <= w_m;
         r_v2  <= r_v1;
         r_res <= (w_t >= (PQLEN+1)'(prime_i)) ? PQLEN'(w_t - (PQLEN+1)'(prime_i))
                                                : w_t[PQLEN-1:0];
         r_v3  <= r_v2;
      end
   end

   assign out_valid_o = r_v3;
   assign res_o       = r_res;

endmodule

// File: rtl/otbn_pq_trcu_seq.sv
// otbn_pq_trcu_seq: twiddle recompute unit between the PQ decoder and ALU.
// Holds twiddle, omega[0..7], psi[0..7] and their indices; runs twiddle /
// omega / psi updates through a Montgomery multiplier.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   op_valid_i / op_ready_o       op handshake; accepted when both high
//   op_i                          trcu_op_e
//   omega_idx_inc_i, psi_idx_inc_i  bump the index when the op completes
//   prime_i, prime_dash_i         q and -q^-1 mod 2^32
//   wr_en_i, wr_sel_i, wr_data_i  ISPR write port (trcu_wsel_e)
//   twiddle_o, omega_o, psi_o     register contents (slot0 in bits [31:0])
//   omega_idx_o, psi_idx_o        current indices
//   done_o                        one-cycle pulse on op completion
//   err_o                         one-cycle pulse after a dropped write
// Handshake: an op transfers on a cycle where op_valid_i & op_ready_o; the
// requester holds op_valid_i/op_i until then. op_ready_o is the only output
// with a combinational path (from the sequencer state only).
module otbn_pq_trcu_seq
   import otbn_pq_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    op_valid_i,
   output logic                    op_ready_o,
   input  logic [2:0]              op_i,
   input  logic                    omega_idx_inc_i,
   input  logic                    psi_idx_inc_i,
   input  logic [PQLEN-1:0]        prime_i,
   input  logic [PQLEN-1:0]        prime_dash_i,
   input  logic                    wr_en_i,
   input  logic [4:0]              wr_sel_i,
   input  logic [PQLEN-1:0]        wr_data_i,
   output logic [PQLEN-1:0]        twiddle_o,
   output logic [NSlots*PQLEN-1:0] omega_o,
   output logic [NSlots*PQLEN-1:0] psi_o,
   output logic [2:0]              omega_idx_o,
   output logic [2:0]              psi_idx_o,
   output logic                    done_o,
   output logic                    err_o
);

   logic [PQLEN-1:0] r_twiddle;
   logic [PQLEN-1:0] r_omega [NSlots];
   logic [PQLEN-1:0] r_psi   [NSlots];
   logic [2:0]       r_omega_idx, r_psi_idx;

   trcu_state_e r_state, w_state_d;
   logic [1:0]  r_stage, w_stage_d;   // cycle number within a multiply op
   trcu_op_e    r_op;
   logic        r_omega_inc, r_psi_inc;
   logic [2:0]  r_tgt_idx;            // slot the multiply result lands in
   logic        r_done, r_err;

   trcu_op_e         w_op;
   logic             w_accept, w_is_mul, w_wb, w_wr_idle;
   logic             w_done_d, w_err_d;
   logic [2:0]       w_omega_slot, w_psi_slot;
   logic [PQLEN-1:0] w_mul_a, w_mul_b, w_mul_res;
   logic             w_mul_valid;

   assign w_op       = trcu_op_e'(op_i);
   assign w_is_mul   = trcu_is_mul(w_op);
   assign op_ready_o = (r_state == TRCU_IDLE);
   assign w_accept   = op_valid_i & op_ready_o;
   // Writes while a multiply is in flight are dropped.
   assign w_wr_idle  = wr_en_i & (r_state == TRCU_IDLE);
   assign w_wb       = w_mul_valid & (r_state == TRCU_BUSY) &
                       (r_stage == 2'(TrcuMulLatency));
   assign w_omega_slot = 3'(wr_sel_i - TRCU_WSEL_OMEGA0);
   assign w_psi_slot   = 3'(wr_sel_i - TRCU_WSEL_PSI0);

   // Sequencer next state and pulse outputs.
   always_comb begin
      w_state_d = r_state;
      w_stage_d = r_stage;
      w_done_d  = 1'b0;
      w_err_d   = 1'b0;
      case (r_state)
         TRCU_IDLE: begin
            if (w_accept) begin
               if (w_is_mul) begin
                  w_state_d = TRCU_BUSY;
                  w_stage_d = 2'd1;
               end else begin
                  w_done_d = 1'b1;
               end
            end
         end
         TRCU_BUSY: begin
            w_err_d   = wr_en_i;
            w_stage_d = r_stage + 2'd1;
            // done_o is registered, so raise it one stage ahead of writeback.
            if (r_stage == 2'(TrcuMulLatency - 1)) w_done_d = 1'b1;
            if (r_stage == 2'(TrcuMulLatency)) begin
               w_state_d = TRCU_IDLE;
               w_stage_d = 2'd0;
            end
         end
         default: w_state_d = TRCU_IDLE;
      endcase
   end

   // Operands are taken from the registers before any same-cycle write.
   always_comb begin
      w_mul_a = r_twiddle;
      w_mul_b = r_omega[r_omega_idx];
      case (w_op)
         TRCU_OP_UPD_OMEGA: begin
            w_mul_a = r_omega[r_omega_idx];
            w_mul_b = r_omega[r_omega_idx];
         end
         TRCU_OP_UPD_PSI: begin
            w_mul_a = r_psi[r_psi_idx];
            w_mul_b = r_psi[r_psi_idx];
         end
         default: ;
      endcase
   end

   otbn_pq_mont_mul u_mont_mul (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .in_valid_i   (w_accept & w_is_mul),
      .a_i          (w_mul_a),
      .b_i          (w_mul_b),
      .prime_i      (prime_i),
      .prime_dash_i (prime_dash_i),
      .out_valid_o  (w_mul_valid),
      .res_o        (w_mul_res)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= TRCU_IDLE;
         r_stage     <= 2'd0;
         r_op        <= TRCU_OP_NONE;
         r_omega_inc <= 1'b0;
         r_psi_inc   <= 1'b0;
         r_tgt_idx   <= 3'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_twiddle   <= '0;
         r_omega_idx <= 3'd0;
         r_psi_idx   <= 3'd0;
         for (int i = 0; i < NSlots; i++) begin
            r_omega[i] <= '0;
            r_psi[i]   <= '0;
         end
      end else begin
         r_state <= w_state_d;
         r_stage <= w_stage_d;
         r_done  <= w_done_d;
         r_err   <= w_err_d;

         if (w_accept) begin
            r_op        <= w_op;
            r_omega_inc <= omega_idx_inc_i;
            r_psi_inc   <= psi_idx_inc_i;
            r_tgt_idx   <= (w_op == TRCU_OP_UPD_PSI) ? r_psi_idx : r_omega_idx;
         end

         if (w_wr_idle) begin
            if (wr_sel_i == TRCU_WSEL_TWIDDLE) begin
               r_twiddle <= wr_data_i;
            end else if (wr_sel_i >= TRCU_WSEL_OMEGA0 && wr_sel_i <= TRCU_WSEL_OMEGA7) begin
               r_omega[w_omega_slot] <= wr_data_i;
            end else if (wr_sel_i >= TRCU_WSEL_PSI0 && wr_sel_i <= TRCU_WSEL_PSI7) begin
               r_psi[w_psi_slot] <= wr_data_i;
            end else if (wr_sel_i == TRCU_WSEL_OMEGA_IDX) begin
               r_omega_idx <= wr_data_i[2:0];
            end else if (wr_sel_i == TRCU_WSEL_PSI_IDX) begin
               r_psi_idx <= wr_data_i[2:0];
            end
         end

         // Single-cycle ops complete at the acceptance edge.
         if (w_accept && !w_is_mul) begin
            case (w_op)
               TRCU_OP_SET_TW_PSI:  r_twiddle <= r_psi[r_psi_idx];
               TRCU_OP_INV_TWIDDLE: r_twiddle <= (r_twiddle == '0) ? '0
                                                 : prime_i - r_twiddle;
               default: ;
            endcase
            if (omega_idx_inc_i) r_omega_idx <= r_omega_idx + 3'd1;
            if (psi_idx_inc_i)   r_psi_idx   <= r_psi_idx + 3'd1;
         end

         if (w_wb) begin
            case (r_op)
               TRCU_OP_UPD_TWIDDLE: r_twiddle          <= w_mul_res;
               TRCU_OP_UPD_OMEGA:   r_omega[r_tgt_idx] <= w_mul_res;
               TRCU_OP_UPD_PSI:     r_psi[r_tgt_idx]   <= w_mul_res;
               default: ;
            endcase
            if (r_omega_inc) r_omega_idx <= r_omega_idx + 3'd1;
            if (r_psi_inc)   r_psi_idx   <= r_psi_idx + 3'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NSlots; i++) begin
         omega_o[i*PQLEN +: PQLEN] = r_omega[i];
         psi_o[i*PQLEN +: PQLEN]   = r_psi[i];
      end
   end

   assign twiddle_o   = r_twiddle;
   assign omega_idx_o = r_omega_idx;
   assign psi_idx_o   = r_psi_idx;
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule
